// File: rtl/nvram_upload_ctrl_pkg.sv
// Shared types and constants for the CMOS NVRAM upload path.
package nvram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        QUIET,
        REQ,
        XFER
    } nv_state_t;

    localparam logic [7:0] NV_INDEX_DEF = 8'd4;
    localparam logic [3:0] DIN_PAD      = 4'hF;
    localparam logic [7:0] DIN_IDLE     = 8'hFF;

endpackage

// File: rtl/nvram_upload_ctrl_if.sv
// HPS ioctl upload bus: hps_io is the master, the NVRAM responder is the slave.
interface nvram_upload_ctrl_if;
    logic        ioctl_upload;
    logic [7:0]  ioctl_index;
    logic        ioctl_rd;
    logic [16:0] ioctl_addr;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic        ioctl_upload_req;

    modport master (
        output ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr,
        input  ioctl_din, ioctl_wait, ioctl_upload_req
    );

    modport slave (
        input  ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr,
        output ioctl_din, ioctl_wait, ioctl_upload_req
    );
endinterface

// File: rtl/nvram_rd_pipe.sv
// Sequences one HPS read into a CMOS port-B fetch, stalling the HPS until the
// nibble has come back through RAM_LAT cycles of read latency.
module nvram_rd_pipe
    import nvram_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int RAM_LAT = 1
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              en,
    input  logic              abort,
    input  logic              rd,
    input  logic [16:0]       addr,
    input  logic [3:0]        ram_q,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd,
    output logic [7:0]        din,
    output logic              stall
);

    // stage_reg[0] is the RAM read cycle; stage_reg[RAM_LAT] is the cycle ram_q is valid.
    logic [RAM_LAT:0]  stage_reg;
    logic [RAM_LAT:0]  stage_next;
    logic [ADDR_W-1:0] ram_addr_reg;
    logic [7:0]        din_reg;
    logic              in_range;
    logic              busy;
    logic              accept;
    logic              reject;

    assign in_range = (addr >> ADDR_W) == 17'd0;
    assign busy     = |stage_reg;
    assign accept   = en && rd && !busy && in_range;
    assign reject   = en && rd && !busy && !in_range;

    assign stage_next[0] = accept && !abort;
    generate
        for (genvar gi = 1; gi <= RAM_LAT; gi++) begin : g_stage
            assign stage_next[gi] = stage_reg[gi-1] && !abort;
        end
    endgenerate

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            stage_reg    <= '0;
            ram_addr_reg <= '0;
            din_reg      <= DIN_IDLE;
        end else begin
            stage_reg <= stage_next;
            if (accept) begin
                ram_addr_reg <= addr[ADDR_W-1:0];
            end
            if (stage_reg[RAM_LAT]) begin
                din_reg <= {DIN_PAD, ram_q};
            end else if (reject) begin
                din_reg <= DIN_IDLE;
            end
        end
    end

    assign ram_addr = ram_addr_reg;
    assign ram_rd   = stage_reg[0];
    assign din      = din_reg;
    assign stall    = |stage_reg[RAM_LAT:1];

endmodule

// File: rtl/nvram_upload_ctrl.sv
// Serves Williams CMOS RAM back to the HPS as an ioctl upload, requesting a save
// once CPU writes have been quiet for QUIET_CYCLES or on an OSD forced save.
module nvram_upload_ctrl
    import nvram_pkg::*;
#(
    parameter int         ADDR_W       = 10,
    parameter logic [7:0] NV_INDEX     = NV_INDEX_DEF,
    parameter int         RAM_LAT      = 1,
    parameter int         QUIET_CYCLES = 12000000,
    parameter int         QUIET_W      = 24
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic                cpu_cmos_we,
    input  logic                save_now,
    nvram_upload_ctrl_if.slave  hps,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic                ram_rd,
    input  logic [3:0]          ram_q,
    output logic                dirty
);

    localparam logic [QUIET_W-1:0] QUIET_LAST = QUIET_W'(QUIET_CYCLES - 1);
    localparam logic [QUIET_W-1:0] CNT_MAX    = '1;

    nv_state_t          state_reg, state_next;
    logic [QUIET_W-1:0] cnt_reg, cnt_next;
    logic               dirty_reg, dirty_next;
    logic               pending_reg, pending_next;
    logic               my_up;
    logic               xfer_en;
    logic               xfer_abort;

    assign my_up      = hps.ioctl_upload && (hps.ioctl_index == NV_INDEX);
    assign xfer_en    = (state_reg == XFER) && my_up;
    assign xfer_abort = (state_reg == XFER) && !my_up;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            dirty_reg   <= 1'b0;
            pending_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            dirty_reg   <= dirty_next;
            pending_reg <= pending_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        dirty_next   = dirty_reg | cpu_cmos_we;
        pending_next = pending_reg;
        case (state_reg)
            IDLE: begin
                if (save_now) begin
                    state_next = REQ;
                end else if (cpu_cmos_we) begin
                    state_next = QUIET;
                    cnt_next   = '0;
                end
            end
            QUIET: begin
                if (save_now) begin
                    state_next = REQ;
                end else if (cpu_cmos_we) begin
                    cnt_next = '0;
                end else if (cnt_reg == QUIET_LAST) begin
                    state_next = REQ;
                end else if (cnt_reg != CNT_MAX) begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            REQ: begin
                // A write landing on the accept edge still counts as a change.
                if (my_up) begin
                    state_next   = XFER;
                    dirty_next   = cpu_cmos_we;
                    pending_next = 1'b0;
                end
            end
            XFER: begin
                if (cpu_cmos_we) begin
                    pending_next = 1'b1;
                end
                if (!my_up) begin
                    pending_next = 1'b0;
                    if (pending_reg || cpu_cmos_we) begin
                        state_next = QUIET;
                        cnt_next   = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign hps.ioctl_upload_req = (state_reg == REQ);
    assign dirty                = dirty_reg;

    nvram_rd_pipe #(
        .ADDR_W  (ADDR_W),
        .RAM_LAT (RAM_LAT)
    ) u_rd_pipe (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .en       (xfer_en),
        .abort    (xfer_abort),
        .rd       (hps.ioctl_rd),
        .addr     (hps.ioctl_addr),
        .ram_q    (ram_q),
        .ram_addr (ram_addr),
        .ram_rd   (ram_rd),
        .din      (hps.ioctl_din),
        .stall    (hps.ioctl_wait)
    );

endmodule

// File: doc/nvram_upload_ctrl.md
Name: nvram_upload_ctrl

Overview:
- Responder side of the HPS ioctl transfer path. The existing download path writes ROM/NVRAM into the core; this block serves the Williams CMOS RAM back to the HPS as an upload so high scores and settings persist.
- Tracks CPU writes to CMOS and requests an upload once writes have been quiet for a set period.
- Answers each HPS read strobe by fetching the CMOS nibble, stalling the HPS with ioctl_wait until the data is valid.
- Sits in the top level, between hps_io and the CMOS RAM's second (read) port.

Parameters:
- ADDR_W, 10, CMOS address width (1K x 4).
- NV_INDEX, 4, ioctl_index value that selects NVRAM upload.
- RAM_LAT, 1, CMOS port-B read latency in clk_sys cycles (1..3).
- QUIET_CYCLES, 12000000, quiet cycles after the last CPU write before a request is raised (1 s at 12 MHz).
- QUIET_W, 24, width of the quiet counter.

Ports:
- clk_sys, in, 1, system clock (12 MHz).
- reset, in, 1, asynchronous, active-high.
- cpu_cmos_we, in, 1, CPU write strobe to CMOS, one cycle per write.
- save_now, in, 1, OSD forced-save pulse.
- ioctl_upload, in, 1, HPS upload active.
- ioctl_index, in, 8, transfer index.
- ioctl_rd, in, 1, HPS read strobe, one cycle.
- ioctl_addr, in, 17, byte address of the read.
- ioctl_din, out, 8, read data to the HPS.
- ioctl_wait, out, 1, stalls the HPS until ioctl_din is valid.
- ioctl_upload_req, out, 1, upload request to the HPS.
- ram_addr, out, ADDR_W, CMOS port-B address.
- ram_rd, out, 1, CMOS port-B read enable.
- ram_q, in, 4, CMOS port-B data.
- dirty, out, 1, CMOS changed since the last completed upload.

Behaviour:
- Reset values: ioctl_din=8'hFF, ioctl_wait=0, ioctl_upload_req=0, ram_addr=0, ram_rd=0, dirty=0. State=IDLE, quiet counter=0.
- Upload match: my_up = ioctl_upload && (ioctl_index==NV_INDEX).
- FSM states: IDLE, QUIET, REQ, XFER.
- IDLE:
  - cpu_cmos_we -> dirty=1, counter=0, go to QUIET.
  - save_now -> go to REQ, regardless of dirty.
- QUIET:
  - Each cpu_cmos_we clears the counter.
  - Otherwise the counter increments each cycle.
  - When counter == QUIET_CYCLES-1 -> REQ. The request is raised QUIET_CYCLES cycles after the last write.
  - save_now -> REQ immediately.
- REQ:
  - ioctl_upload_req=1, held until my_up rises.
  - On my_up -> XFER, req drops the same edge, dirty clears.
- XFER:
  - On ioctl_rd with ioctl_addr < 2**ADDR_W: ram_addr=ioctl_addr[ADDR_W-1:0], ram_rd=1 for one cycle, ioctl_wait=1 from the next cycle.
  - After RAM_LAT cycles: ioctl_din={4'hF, ram_q} registered, and ioctl_wait drops in that same cycle.
  - Total stall from ioctl_rd to wait low: RAM_LAT+1 cycles.
  - On ioctl_rd with an out-of-range address: ioctl_din=8'hFF next cycle, no wait, no RAM access.
  - An ioctl_rd arriving while wait=1 is an HPS protocol violation and is ignored (not queued).
  - my_up falling -> IDLE. If ioctl_wait was high at that point, it is forced low.
- CPU writes during XFER set dirty=1 and a pending flag. On exit from XFER, pending -> QUIET (counter=0); otherwise -> IDLE.
- An upload with a non-matching index is ignored in every state. A request held in REQ stays held.
- A simultaneous cpu_cmos_we and save_now in IDLE/QUIET -> REQ with dirty=1.
- ioctl_din holds its last value between reads.
- Reset mid-XFER: all outputs return asynchronously to their reset values. Any half-served read is abandoned.
- Counter saturates; it never wraps back to 0 without a write.

Decomposition:
- Shared package nvram_pkg holds:
  - FSM state enum (IDLE, QUIET, REQ, XFER).
  - NV_INDEX default.
  - Constant DIN_PAD=4'hF.
- One natural sub-module: nvram_rd_pipe. It handles the ioctl_rd -> ram_rd -> ioctl_wait/ioctl_din latency sequencing for RAM_LAT, leaving the FSM in the parent.

Test Plan:
- Reset, then one cpu_cmos_we at t0 (QUIET_CYCLES=100 for sim) -> dirty=1 at t0+1; ioctl_upload_req rises at t0+100, not before.
- Writes at t0 and t0+50 -> req rises at t0+150; a third write in between restarts the count again.
- REQ, then ioctl_upload=1 with ioctl_index=4 -> req drops, dirty=0. With ioctl_index=0 instead -> req stays 1.
- XFER, CMOS[0x155]=4'hA, ioctl_rd with addr 0x155, RAM_LAT=1 -> ram_rd pulse, wait high 1 cycle then low, ioctl_din=8'hFA. Repeat with RAM_LAT=3 -> wait high 3 cycles.
- ioctl_rd with addr 0x400 -> ioctl_din=8'hFF next cycle, wait never asserts, ram_rd stays 0.
- cpu_cmos_we mid-XFER, then upload ends -> state QUIET, dirty=1, new req after QUIET_CYCLES. Separately, reset asserted while wait=1 -> wait=0, din=FF, req=0 immediately.
